// File: rtl/exe_div_ctrl.sv
// Iterative restoring radix-2 divider for the EXE stage: div.w/mod.w/div.wu/mod.wu.
// Fixed 35-cycle latency from accept to out_valid; the result is held until MEM takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; req_ready high
// S_PREP | take magnitudes, record result signs, clear rem/cnt
// S_CALC | one quotient bit per cycle, 32 cycles, MSB first
// S_FIX  | apply signs and select quotient or remainder
// S_DONE | out_valid high, result held until out_ready
module exe_div_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [31:0] result_q, result_d;
   logic        req_ready_q, req_ready_d;
   logic        busy_q, busy_d;
   logic        out_valid_q, out_valid_d;

   logic [32:0] trial;
   logic [32:0] diff;
   logic        is_signed;
   logic        is_mod;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      result_d    = result_q;

      // The remainder stays below the divisor, so 32 bits of rem plus the next
      // dividend bit always fit the 33-bit trial value.
      trial     = {rem_q, dvd_q[31]};
      diff      = trial - {1'b0, dvs_q};
      is_signed = op_q[3] | op_q[2];
      is_mod    = op_q[2] | op_q[0];
      quo_fix   = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
      rem_fix   = r_neg_q ? (~rem_q + 32'd1) : rem_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               op_d    = req_op;
               dvd_d   = src1;
               dvs_d   = src2;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            // Divide by zero keeps the raw dividend so the remainder comes out unchanged.
            if (is_signed && (dvs_q != 32'd0)) begin
               dvd_d   = dvd_q[31] ? (~dvd_q + 32'd1) : dvd_q;
               dvs_d   = dvs_q[31] ? (~dvs_q + 32'd1) : dvs_q;
               q_neg_d = dvd_q[31] ^ dvs_q[31];
               r_neg_d = dvd_q[31];
            end
            state_d = S_CALC;
         end
         S_CALC: begin
            if (!diff[32]) begin
               rem_d = diff[31:0];
               dvd_d = {dvd_q[30:0], 1'b1};
            end else begin
               rem_d = trial[31:0];
               dvd_d = {dvd_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = is_mod ? rem_fix : quo_fix;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d = S_IDLE;
      end

      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         op_q        <= 4'd0;
         dvd_q       <= 32'd0;
         dvs_q       <= 32'd0;
         rem_q       <= 32'd0;
         cnt_q       <= 5'd0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         result_q    <= 32'd0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         result_q    <= result_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed bench for exe_div_ctrl: vector table for the arithmetic plus
// hand-written sequences for back-pressure, flush and mid-operation reset.
module tb_exe_div_ctrl;

   localparam logic [3:0] OP_DIV_W  = 4'b1000;
   localparam logic [3:0] OP_MOD_W  = 4'b0100;
   localparam logic [3:0] OP_DIV_WU = 4'b0010;
   localparam logic [3:0] OP_MOD_WU = 4'b0001;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exe_div_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present a request in the low phase; returns #1 after the accept edge (cycle 1).
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      src1      = a;
      src2      = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 4'b1000;
      src1      = 32'hDEADBEEF;
      src2      = 32'h00000003;
   endtask

   // Starting in cycle 1, advance until out_valid; lat is the cycle it was seen in.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int stall);
      int lat;
      issue(op, a, b);
      chk({name, " busy_c1"}, {31'd0, busy}, 32'd1);
      wait_valid(lat);
      chk({name, " latency"}, lat, 32'd35);
      chk({name, " result"}, result, exp);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s hold%0d valid", name, i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("%s hold%0d result", name, i), result, exp);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, " idle_valid"}, {31'd0, out_valid}, 32'd0);
      chk({name, " idle_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      int bad;

      vecs[0]  = '{"divw_m7_2",    OP_DIV_W,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
      vecs[1]  = '{"modw_m7_2",    OP_MOD_W,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
      vecs[2]  = '{"divwu_ff_2",   OP_DIV_WU, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF};
      vecs[3]  = '{"modwu_ff_2",   OP_MOD_WU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
      vecs[4]  = '{"divw_by0",     OP_DIV_W,  32'h12345678, 32'h00000000, 32'hFFFFFFFF};
      vecs[5]  = '{"modw_by0",     OP_MOD_W,  32'h12345678, 32'h00000000, 32'h12345678};
      vecs[6]  = '{"divw_ovf",     OP_DIV_W,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vecs[7]  = '{"modw_ovf",     OP_MOD_W,  32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      vecs[8]  = '{"divwu_100_7",  OP_DIV_WU, 32'd100,      32'd7,        32'd14};
      vecs[9]  = '{"modwu_100_7",  OP_MOD_WU, 32'd100,      32'd7,        32'd2};
      vecs[10] = '{"divw_7_m2",    OP_DIV_W,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
      vecs[11] = '{"modw_7_m2",    OP_MOD_W,  32'd7,        32'hFFFFFFFE, 32'h00000001};
      vecs[12] = '{"modw_neg_by0", OP_MOD_W,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
      vecs[13] = '{"divw_neg_by0", OP_DIV_W,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF};
      vecs[14] = '{"modwu_by0",    OP_MOD_WU, 32'h87654321, 32'h00000000, 32'h87654321};
      vecs[15] = '{"divw_m100_m7", OP_DIV_W,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14};

      resetn    = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'b0000;
      src1      = 32'd0;
      src2      = 32'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #23;
      chk("rst ready", {31'd0, req_ready}, 32'd1);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst valid", {31'd0, out_valid}, 32'd0);
      chk("rst result", result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst ready", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
      end

      // Result held for 4 valid cycles while out_ready stays low for 3.
      run_op("bp_divw_50_5", OP_DIV_W, 32'd50, 32'd5, 32'd10, 3);

      // Flush during cycle 10, then re-issue in cycle 11.
      issue(OP_DIV_WU, 32'd100, 32'd7);
      bad = 0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (out_valid || !busy) bad++;
      end
      chk("flush pre busy/valid", bad, 32'd0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush busy_c11", {31'd0, busy}, 32'd0);
      chk("flush valid_c11", {31'd0, out_valid}, 32'd0);
      chk("flush ready_c11", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = OP_DIV_WU;
      src1      = 32'd100;
      src2      = 32'd7;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_valid(lat);
      chk("flush reissue cycle", 11 + lat, 32'd46);
      chk("flush reissue result", result, 32'd14);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("flush reissue idle", {31'd0, req_ready}, 32'd1);

      // Flush in DONE wins over out_ready.
      issue(OP_DIV_WU, 32'd9, 32'd3);
      wait_valid(lat);
      chk("done result", result, 32'd3);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      chk("done flush valid", {31'd0, out_valid}, 32'd0);
      chk("done flush busy", {31'd0, busy}, 32'd0);

      // Flush together with req_valid in IDLE: nothing accepted.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_DIV_W;
      src1      = 32'd20;
      src2      = 32'd4;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      chk("idle flush no accept", {31'd0, busy}, 32'd0);
      chk("idle flush ready", {31'd0, req_ready}, 32'd1);

      // Asynchronous reset at cycle 20 of an operation.
      issue(OP_DIV_W, 32'd50, 32'd5);
      repeat (19) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("mid_rst ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst busy", {31'd0, busy}, 32'd0);
      chk("mid_rst valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst result", result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy || !req_ready) bad++;
      end
      chk("post_rst no stale", bad, 32'd0);

      run_op("post_rst divw_50_5", OP_DIV_W, 32'd50, 32'd5, 32'd10, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
